// File: rtl/mul_pkg.sv
// Shared arithmetic-datapath definitions: multiplier FSM states and result-width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic int unsigned res_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/add_n.sv
// Parametrised N-bit ripple adder with carry-in and carry-out.
module add_n #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
  assign o_sum  = w_full[N-1:0];
  assign o_cout = w_full[N];

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier: A_W x B_W product over B_W cycles, signed or unsigned
// per transaction, valid/ready on both sides.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned A_W = 4,
  parameter int unsigned B_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] res
);

  localparam int unsigned RW = res_width(A_W, B_W);
  localparam int unsigned CW = $clog2(B_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(B_W - 1);

  mul_state_t      r_state;
  logic [A_W-1:0]  r_mcand;
  logic [B_W-1:0]  r_mplier;
  logic            r_neg;
  logic [RW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_res;
  logic            r_out_valid;

  logic [A_W-1:0]  w_a_mag;
  logic [B_W-1:0]  w_b_mag;
  logic [RW-1:0]   w_addend;
  logic [RW-1:0]   w_acc_next;
  logic [RW-1:0]   w_acc_neg;
  logic            w_acc_cout_unused;
  logic            w_neg_cout_unused;

  // Most-negative operand negates to 2^(W-1), which still fits as an unsigned magnitude.
  always_comb begin
    w_a_mag = a;
    w_b_mag = b;
    if (signed_mode && a[A_W-1]) w_a_mag = ~a + 1'b1;
    if (signed_mode && b[B_W-1]) w_b_mag = ~b + 1'b1;
  end

  always_comb begin
    w_addend = '0;
    if (r_mplier[r_cnt]) w_addend = RW'(r_mcand) << r_cnt;
  end

  add_n #(.N(RW)) u_acc_add (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_acc_next),
    .o_cout (w_acc_cout_unused)
  );

  // Two's-complement negation of the final sum: ~x + 1.
  add_n #(.N(RW)) u_neg_add (
    .i_a    (~w_acc_next),
    .i_b    ('0),
    .i_cin  (1'b1),
    .o_sum  (w_acc_neg),
    .o_cout (w_neg_cout_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= signed_mode & (a[A_W-1] ^ b[B_W-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt == CNT_LAST) begin
            r_res       <= r_neg ? w_acc_neg : w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign res       = r_res;

endmodule
